// File: rtl/legv8_multicycle_ctrl.sv
// Multicycle LEGv8 control FSM: decodes IR[31:21], sequences FETCH..WB, counts retirements.
// Optional MULTICYCLE_MEM_WAIT_EN holds the MEM state until i_mem_ready is high.
module legv8_multicycle_ctrl #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic [10:0]      i_opcode,
  input  logic             i_zero,
  input  logic             i_mem_ready,
  output logic [1:0]       o_sign_op,
  output logic [3:0]       o_alu_op,
  output logic             o_reg2loc,
  output logic             o_alu_src,
  output logic             o_mem_to_reg,
  output logic             o_reg_write,
  output logic             o_mem_read,
  output logic             o_mem_write,
  output logic             o_ir_write,
  output logic             o_pc_write,
  output logic             o_pc_src,
  output logic             o_illegal,
  output logic [CNT_W-1:0] o_instr_count
);

  typedef enum logic [2:0] {StFetch, StDecode, StExec, StMem, StWb, StHalt} state_e;
  typedef enum logic [3:0] {
    ClsLdur, ClsStur, ClsAdd, ClsSub, ClsAnd, ClsOrr, ClsAddi, ClsSubi, ClsCbz, ClsB, ClsIllegal
  } cls_e;

  state_e           r_state;
  state_e           w_state_next;
  cls_e             w_cls;
  logic             r_illegal;
  logic [CNT_W-1:0] r_count;
  logic             w_mem_done;
  logic             w_retire;

`ifdef MULTICYCLE_MEM_WAIT_EN
  assign w_mem_done = i_mem_ready;
`else
  logic w_unused_mem_ready;
  assign w_unused_mem_ready = i_mem_ready;
  assign w_mem_done         = 1'b1;
`endif

  always_comb begin
    w_cls = ClsIllegal;
    casez (i_opcode)
      11'b11111000010: w_cls = ClsLdur;
      11'b11111000000: w_cls = ClsStur;
      11'b10001011000: w_cls = ClsAdd;
      11'b11001011000: w_cls = ClsSub;
      11'b10001010000: w_cls = ClsAnd;
      11'b10101010000: w_cls = ClsOrr;
      11'b1001000100?: w_cls = ClsAddi;
      11'b1101000100?: w_cls = ClsSubi;
      11'b10110100???: w_cls = ClsCbz;
      11'b000101?????: w_cls = ClsB;
      default:         w_cls = ClsIllegal;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= StFetch;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      StFetch:  w_state_next = StDecode;
      StDecode: w_state_next = (w_cls == ClsIllegal) ? StHalt : StExec;
      StExec: begin
        if (w_cls == ClsCbz || w_cls == ClsB) begin
          w_state_next = StFetch;
        end else if (w_cls == ClsLdur || w_cls == ClsStur) begin
          w_state_next = StMem;
        end else begin
          w_state_next = StWb;
        end
      end
      StMem: begin
        if (w_mem_done) begin
          w_state_next = (w_cls == ClsLdur) ? StWb : StFetch;
        end
      end
      StWb:    w_state_next = StFetch;
      StHalt:  w_state_next = StHalt;
      default: w_state_next = StFetch;
    endcase
  end

  always_comb begin
    o_sign_op    = 2'b00;
    o_alu_op     = 4'b0000;
    o_reg2loc    = 1'b0;
    o_alu_src    = 1'b0;
    o_mem_to_reg = 1'b0;
    o_reg_write  = 1'b0;
    o_mem_read   = 1'b0;
    o_mem_write  = 1'b0;
    o_ir_write   = 1'b0;
    o_pc_write   = 1'b0;
    o_pc_src     = 1'b0;
    w_retire     = 1'b0;
    if (!i_reset) begin
      case (r_state)
        StFetch: o_ir_write = 1'b1;
        StDecode: begin
          o_reg2loc = (w_cls == ClsStur) || (w_cls == ClsCbz);
          case (w_cls)
            ClsLdur, ClsStur: o_sign_op = 2'b00;
            ClsCbz:           o_sign_op = 2'b01;
            ClsB:             o_sign_op = 2'b10;
            ClsAddi, ClsSubi: o_sign_op = 2'b11;
            default:          o_sign_op = 2'b00;
          endcase
        end
        StExec: begin
          o_alu_src = (w_cls == ClsLdur) || (w_cls == ClsStur) ||
                      (w_cls == ClsAddi) || (w_cls == ClsSubi);
          case (w_cls)
            ClsAdd, ClsAddi, ClsLdur, ClsStur: o_alu_op = 4'b0010;
            ClsSub, ClsSubi:                   o_alu_op = 4'b0110;
            ClsOrr:                            o_alu_op = 4'b0001;
            ClsCbz:                            o_alu_op = 4'b0111;
            default:                           o_alu_op = 4'b0000;
          endcase
          if (w_cls == ClsCbz || w_cls == ClsB) begin
            o_pc_write = 1'b1;
            o_pc_src   = (w_cls == ClsB) ? 1'b1 : i_zero;
            w_retire   = 1'b1;
          end
        end
        StMem: begin
          o_mem_read  = (w_cls == ClsLdur);
          o_mem_write = (w_cls == ClsStur);
          // A store retires from MEM, but only once memory has accepted it.
          if (w_cls == ClsStur && w_mem_done) begin
            o_pc_write = 1'b1;
            w_retire   = 1'b1;
          end
        end
        StWb: begin
          o_reg_write  = 1'b1;
          o_mem_to_reg = (w_cls == ClsLdur);
          o_pc_write   = 1'b1;
          w_retire     = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_illegal <= 1'b0;
      r_count   <= '0;
    end else begin
      if (r_state == StDecode && w_cls == ClsIllegal) begin
        r_illegal <= 1'b1;
      end
      if (w_retire) begin
        r_count <= r_count + 1'b1;
      end
    end
  end

  assign o_illegal     = r_illegal;
  assign o_instr_count = r_count;

endmodule

// File: tb/tb_legv8_multicycle_ctrl.sv
// Bench for legv8_multicycle_ctrl: directed cycle table, random instruction stream against a
// per-instruction cycle-script model, and hand sequences for reset, HALT and memory wait.
module tb_legv8_multicycle_ctrl;

  localparam int unsigned CW = 4;  // narrow counter so the random stream wraps it repeatedly

  localparam logic [15:0] IRW = 16'h0008, PCW = 16'h0004, PCS = 16'h0002, ILL = 16'h0001;
  localparam logic [15:0] MW = 16'h0010, MR = 16'h0020, RW = 16'h0040, M2R = 16'h0080;
  localparam logic [15:0] ASRC = 16'h0100, R2L = 16'h0200;
  localparam logic [15:0] SO_CB = 16'h4000, SO_B = 16'h8000, SO_I = 16'hC000;
  localparam logic [15:0] A_ADD = 16'h0800, A_SUB = 16'h1800, A_ORR = 16'h0400;
  localparam logic [15:0] A_PB = 16'h1C00;

  localparam logic [10:0] OP_LDUR = 11'b11111000010, OP_STUR = 11'b11111000000;
  localparam logic [10:0] OP_SUB = 11'b11001011000, OP_ADDI = 11'b10010001000;
  localparam logic [10:0] OP_CBZ = 11'b10110100000, OP_B = 11'b00010100000;

  // Class index: 0 LDUR 1 STUR 2 ADD 3 SUB 4 AND 5 ORR 6 ADDI 7 SUBI 8 CBZ 9 B
  logic [10:0] base [10] = '{11'b11111000010, 11'b11111000000, 11'b10001011000,
                             11'b11001011000, 11'b10001010000, 11'b10101010000,
                             11'b10010001000, 11'b11010001000, 11'b10110100000,
                             11'b00010100000};
  logic [10:0] wild [10] = '{11'd0, 11'd0, 11'd0, 11'd0, 11'd0, 11'd0, 11'd1, 11'd1,
                             11'd7, 11'd31};

  logic          clk = 1'b0;
  logic          i_reset, i_zero, i_mem_ready;
  logic [10:0]   i_opcode;
  logic [1:0]    o_sign_op;
  logic [3:0]    o_alu_op;
  logic          o_reg2loc, o_alu_src, o_mem_to_reg, o_reg_write, o_mem_read, o_mem_write;
  logic          o_ir_write, o_pc_write, o_pc_src, o_illegal;
  logic [CW-1:0] o_instr_count;
  logic [15:0]   w_got;
  logic [3:0]    m_cnt;
  int            checks = 0;
  int            errors = 0;

  always #5 clk = ~clk;

  legv8_multicycle_ctrl #(.CNT_W(CW)) dut (
    .i_clk(clk), .i_reset(i_reset), .i_opcode(i_opcode), .i_zero(i_zero),
    .i_mem_ready(i_mem_ready), .o_sign_op(o_sign_op), .o_alu_op(o_alu_op),
    .o_reg2loc(o_reg2loc), .o_alu_src(o_alu_src), .o_mem_to_reg(o_mem_to_reg),
    .o_reg_write(o_reg_write), .o_mem_read(o_mem_read), .o_mem_write(o_mem_write),
    .o_ir_write(o_ir_write), .o_pc_write(o_pc_write), .o_pc_src(o_pc_src),
    .o_illegal(o_illegal), .o_instr_count(o_instr_count)
  );

  assign w_got = {o_sign_op, o_alu_op, o_reg2loc, o_alu_src, o_mem_to_reg, o_reg_write,
                  o_mem_read, o_mem_write, o_ir_write, o_pc_write, o_pc_src, o_illegal};

  typedef struct {
    logic        rst;
    logic [10:0] op;
    logic        z;
    logic [15:0] exp;
    logic [3:0]  cnt;
  } vec_t;
  vec_t tbl [27];

  task automatic step(input logic r, input logic [10:0] op, input logic z, input logic rdy,
                      input logic [15:0] exp, input logic [3:0] ecnt, input string nm);
    @(negedge clk);
    i_reset = r; i_opcode = op; i_zero = z; i_mem_ready = rdy;
    #1;
    checks++;
    if (w_got !== exp) begin
      errors++;
      $display("FAIL %s strobes: got %h want %h", nm, w_got, exp);
    end
    checks++;
    if (o_instr_count !== ecnt) begin
      errors++;
      $display("FAIL %s count: got %0d want %0d", nm, o_instr_count, ecnt);
    end
  endtask

  function automatic logic [15:0] dec_vec(input int k);
    case (k)
      0:       return 16'h0000;
      1:       return R2L;
      6, 7:    return SO_I;
      8:       return SO_CB | R2L;
      9:       return SO_B;
      default: return 16'h0000;
    endcase
  endfunction

  function automatic logic [15:0] exec_vec(input int k, input logic z);
    case (k)
      0, 1, 6: return ASRC | A_ADD;
      2:       return A_ADD;
      3:       return A_SUB;
      4:       return 16'h0000;
      5:       return A_ORR;
      7:       return ASRC | A_SUB;
      8:       return A_PB | PCW | (z ? PCS : 16'h0000);
      default: return PCW | PCS;
    endcase
  endfunction

  // One instruction of class k, starting from FETCH; tracks the retire count.
  task automatic run_instr(input int k);
    logic [10:0] op;
    logic        z, rdy, done;
    int          hold;
    op = base[k] | (11'($urandom) & wild[k]);
    step(1'b0, 11'($urandom), 1'($urandom), 1'($urandom), IRW, m_cnt, "r_fetch");
    step(1'b0, op, 1'($urandom), 1'($urandom), dec_vec(k), m_cnt, "r_decode");
    z = 1'($urandom);
    step(1'b0, op, z, 1'($urandom), exec_vec(k, z), m_cnt, "r_exec");
    if (k >= 8) begin
      m_cnt = m_cnt + 4'd1;
      return;
    end
    if (k <= 1) begin
      hold = 0;
      do begin
        rdy = 1'($urandom);
        if (hold >= 5) rdy = 1'b1;
`ifdef MULTICYCLE_MEM_WAIT_EN
        done = rdy;
`else
        done = 1'b1;
`endif
        step(1'b0, op, 1'($urandom), rdy,
             ((k == 0) ? MR : MW) | ((k == 1 && done) ? PCW : 16'h0000), m_cnt, "r_mem");
        hold++;
      end while (!done);
      if (k == 1) begin
        m_cnt = m_cnt + 4'd1;
        return;
      end
    end
    step(1'b0, op, 1'($urandom), 1'($urandom), RW | PCW | ((k == 0) ? M2R : 16'h0000),
         m_cnt, "r_wb");
    m_cnt = m_cnt + 4'd1;
  endtask

  initial begin
    i_reset = 1'b1; i_opcode = '0; i_zero = 1'b0; i_mem_ready = 1'b1;

    tbl[0]  = '{1'b1, 11'd0,   1'b0, 16'h0000,            4'd0};
    tbl[1]  = '{1'b1, 11'd0,   1'b0, 16'h0000,            4'd0};
    tbl[2]  = '{1'b0, OP_ADDI, 1'b0, IRW,                 4'd0};
    tbl[3]  = '{1'b0, OP_ADDI, 1'b0, SO_I,                4'd0};
    tbl[4]  = '{1'b0, OP_ADDI, 1'b0, ASRC | A_ADD,        4'd0};
    tbl[5]  = '{1'b0, OP_ADDI, 1'b0, RW | PCW,            4'd0};
    tbl[6]  = '{1'b0, OP_LDUR, 1'b0, IRW,                 4'd1};
    tbl[7]  = '{1'b0, OP_LDUR, 1'b0, 16'h0000,            4'd1};
    tbl[8]  = '{1'b0, OP_LDUR, 1'b0, ASRC | A_ADD,        4'd1};
    tbl[9]  = '{1'b0, OP_LDUR, 1'b0, MR,                  4'd1};
    tbl[10] = '{1'b0, OP_LDUR, 1'b0, RW | M2R | PCW,      4'd1};
    tbl[11] = '{1'b0, OP_STUR, 1'b0, IRW,                 4'd2};
    tbl[12] = '{1'b0, OP_STUR, 1'b0, R2L,                 4'd2};
    tbl[13] = '{1'b0, OP_STUR, 1'b0, ASRC | A_ADD,        4'd2};
    tbl[14] = '{1'b0, OP_STUR, 1'b0, MW | PCW,            4'd2};
    tbl[15] = '{1'b0, OP_CBZ,  1'b1, IRW,                 4'd3};
    tbl[16] = '{1'b0, OP_CBZ,  1'b1, SO_CB | R2L,         4'd3};
    tbl[17] = '{1'b0, OP_CBZ,  1'b1, A_PB | PCW | PCS,    4'd3};
    tbl[18] = '{1'b0, OP_CBZ,  1'b0, IRW,                 4'd4};
    tbl[19] = '{1'b0, OP_CBZ,  1'b0, SO_CB | R2L,         4'd4};
    tbl[20] = '{1'b0, OP_CBZ,  1'b0, A_PB | PCW,          4'd4};
    tbl[21] = '{1'b0, OP_B,    1'b0, IRW,                 4'd5};
    tbl[22] = '{1'b0, OP_B,    1'b0, SO_B,                4'd5};
    tbl[23] = '{1'b0, OP_B,    1'b0, PCW | PCS,           4'd5};
    tbl[24] = '{1'b0, OP_SUB,  1'b0, IRW,                 4'd6};
    tbl[25] = '{1'b0, OP_SUB,  1'b0, 16'h0000,            4'd6};
    tbl[26] = '{1'b0, OP_SUB,  1'b0, A_SUB,               4'd6};

    for (int i = 0; i < 27; i++) begin
      step(tbl[i].rst, tbl[i].op, tbl[i].z, 1'b1, tbl[i].exp, tbl[i].cnt,
           $sformatf("tbl%0d", i));
    end
    step(1'b0, OP_SUB, 1'b0, 1'b1, RW | PCW, 4'd6, "tbl_sub_wb");
    m_cnt = 4'd7;

    for (int n = 0; n < 300; n++) begin
      run_instr(int'($urandom_range(0, 9)));
    end

    // Reset in the middle of a load returns to FETCH and clears the count.
    step(1'b0, OP_LDUR, 1'b0, 1'b1, IRW, m_cnt, "mid_fetch");
    step(1'b0, OP_LDUR, 1'b0, 1'b1, 16'h0000, m_cnt, "mid_decode");
    step(1'b0, OP_LDUR, 1'b0, 1'b1, ASRC | A_ADD, m_cnt, "mid_exec");
    step(1'b1, OP_LDUR, 1'b0, 1'b1, 16'h0000, m_cnt, "mid_reset");
    m_cnt = 4'd0;
    step(1'b0, 11'd0, 1'b0, 1'b1, IRW, m_cnt, "mid_refetch");

    // Illegal opcode: sticky flag, HALT with idle strobes until reset.
    step(1'b0, 11'd0, 1'b0, 1'b1, 16'h0000, m_cnt, "ill_decode");
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 11'($urandom), 1'($urandom), 1'($urandom), ILL, m_cnt, "ill_halt");
    end
    step(1'b1, 11'd0, 1'b0, 1'b1, ILL, m_cnt, "ill_reset");
    step(1'b0, OP_LDUR, 1'b0, 1'b1, IRW, m_cnt, "ill_refetch");

`ifdef MULTICYCLE_MEM_WAIT_EN
    step(1'b0, OP_LDUR, 1'b0, 1'b1, 16'h0000, m_cnt, "wait_decode");
    step(1'b0, OP_LDUR, 1'b0, 1'b1, ASRC | A_ADD, m_cnt, "wait_exec");
    for (int i = 0; i < 3; i++) begin
      step(1'b0, OP_LDUR, 1'b0, 1'b0, MR, m_cnt, "wait_hold");
    end
    step(1'b0, OP_LDUR, 1'b0, 1'b1, MR, m_cnt, "wait_mem_done");
    step(1'b0, OP_LDUR, 1'b0, 1'b1, RW | M2R | PCW, m_cnt, "wait_wb");
    m_cnt = m_cnt + 4'd1;
    step(1'b0, OP_LDUR, 1'b0, 1'b1, IRW, m_cnt, "wait_refetch");
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
